// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  NINE    = 4'd9;

    // Largest value representable in the given number of BCD digits (10^digits - 1).
    function automatic longint unsigned bcd_max(input int unsigned digits);
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
import bin2bcd_pkg::*;

module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 when the nibble would reach 10 or more after doubling.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Result, done pulse and overflow flag are registered and held between conversions.
// Optional: define BIN2BCD_AUTO_EN to also start a conversion whenever bin
// differs from the value captured by the previous conversion.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       bin,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_WIDTH - 1);
    localparam longint unsigned   MAX_VAL  = bcd_max(DIGITS);
    localparam logic [BCD_W-1:0]  ALL_NINE = {DIGITS{NINE}};

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic              overflow_q, overflow_d;
    logic              go;
    logic [BCD_W-1:0]  adj;
    logic [SR_W-1:0]   shifted;

`ifdef BIN2BCD_AUTO_EN
    logic [IN_WIDTH-1:0] prev_q, prev_d;
`endif

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (sr_q[IN_WIDTH + g*DIGIT_W +: DIGIT_W]),
                .dout (adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Corrected BCD field rejoined with the remaining binary bits, then shifted left by one.
    always_comb begin
        shifted = {adj, sr_q[IN_WIDTH-1:0]} << 1;
    end

    // Conversion trigger: start port, plus input-change detection when enabled.
    always_comb begin
`ifdef BIN2BCD_AUTO_EN
        go = start || (bin != prev_q);
`else
        go = start;
`endif
    end

    // Next-state and datapath control for IDLE -> SHIFT -> DONE.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_flag_d = ovf_flag_q;
        overflow_d = overflow_q;
`ifdef BIN2BCD_AUTO_EN
        prev_d     = prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    sr_d                 = '0;
                    sr_d[IN_WIDTH-1:0]   = bin;
                    cnt_d                = '0;
                    busy_d               = 1'b1;
                    ovf_flag_d           = 64'(bin) > MAX_VAL;
                    state_d              = SHIFT;
`ifdef BIN2BCD_AUTO_EN
                    prev_d               = bin;
`endif
                end
            end
            SHIFT: begin
                sr_d  = shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = ovf_flag_q ? ALL_NINE : sr_q[SR_W-1 -: BCD_W];
                overflow_d = ovf_flag_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_flag_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef BIN2BCD_AUTO_EN
            prev_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_flag_q <= ovf_flag_d;
            overflow_q <= overflow_d;
`ifdef BIN2BCD_AUTO_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign bcd      = bcd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the 4-digit seven-segment display driver. It turns a binary count into four packed BCD digits, which drive the display's 16-bit value input.
- The BCD output is registered and held between conversions, so the display never shows intermediate values.

Parameters:
- IN_WIDTH, 14, width of the binary input; must be ≥ 4 and ≤ 20.
- DIGITS, 4, number of BCD digits produced; the output width is 4*DIGITS.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  request a conversion of bin; single-cycle or level
- bin  input  IN_WIDTH  unsigned binary value to convert
- bcd  output  4*DIGITS  packed BCD result; digit 0 is in bcd[3:0]
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd updates
- overflow  output  1  registered with bcd; high if the last input exceeded 10^DIGITS-1

Behaviour:
- Reset: one clock and a synchronous active-low reset (clk, rst_n), as already decided. While rst_n=0 at a clk edge:
  - the FSM goes to IDLE;
  - bcd=0, busy=0, done=0, overflow=0;
  - the shift register and counter are cleared.
- A reset during SHIFT aborts the conversion; no done pulse is produced.
- FSM states:
  - IDLE: start=1 → latch bin into the low IN_WIDTH bits of the shift register, clear the BCD field, clear the counter, set busy=1, go to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥5 gets +3, then the whole (4*DIGITS+IN_WIDTH)-bit register shifts left by 1 and the counter increments. When the counter reaches IN_WIDTH-1 (i.e. after IN_WIDTH shifts), go to DONE.
  - DONE (one cycle): register the BCD field into bcd, pulse done=1, set busy=0, update overflow, return to IDLE.
- Latency: start sampled at edge N → busy=1 after edge N → bcd/done valid after edge N+IN_WIDTH+1 (15 cycles for the default). done is high for exactly one cycle.
- start while busy or in DONE: ignored; it is neither queued nor able to corrupt the in-flight conversion.
- bin may change after start is sampled; it is only sampled in IDLE.
- Back-to-back: start held high continuously gives one conversion every IN_WIDTH+2 cycles.
- Overflow rule:
  - Compare the latched input against 10^DIGITS-1 (9999 for the default).
  - If greater: bcd saturates to all-nines (0x9999) and overflow=1.
  - Otherwise: overflow=0.
  - The comparison is made at latch time and stored in a flag register.
- bcd holds its last value until the next DONE; between conversions it changes only on reset.
- Every BCD nibble of a valid result is in 0–9.

Optional Feature:
- Macro: BIN2BCD_AUTO_EN.
- Defined:
  - In IDLE, a conversion also starts automatically when bin differs from the value captured by the previous conversion.
  - The captured value resets to 0, so a nonzero bin after reset triggers one conversion.
  - The start port remains functional.
  - This lets the display follow a free-running counter without external strobes.
- Undefined: conversions start only on start; no compare register is synthesised.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constant DIGIT_W=4;
  - constant NINE=4'd9.
- One sub-module, bcd_digit_adj: combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times via generate inside bin2bcd_seq.
- Counter width is $clog2(IN_WIDTH).

Test Plan:
- Reset, then start with bin=0 → busy high for 14 cycles; bcd=0x0000, done pulses once at cycle 15, overflow=0.
- start with bin=1234 → bcd=0x1234 exactly 15 cycles later; bcd then holds 0x1234 for 20 idle cycles.
- bin=9999 → bcd=0x9999, overflow=0. Then bin=12000 → bcd=0x9999, overflow=1. Then bin=7 → bcd=0x0007, overflow=0.
- start with bin=4321; pulse start with bin=55 at cycle 5 → result 0x4321, only one done pulse, busy never drops early.
- start with bin=8765; deassert rst_n at cycle 7 → bcd=0, busy=0, no done pulse. Then start with bin=42 → bcd=0x0042 with normal latency.
- With BIN2BCD_AUTO_EN and start tied low: bin ramps 0→300, changing every 40 cycles → each new value appears in bcd 16 cycles after the change. Constant bin causes no further done pulses.
